roi_io_harness: RTL and testbench
=================================

# roi_io_harness

Parametrised I/O harness for a reconfigurable region in the partial-reconfiguration flow. It lets a narrow set of package pins drive an ROI of arbitrary width. Serial input data is deserialised over `LANES` lanes into a shadow register, then applied to the ROI input bus in a single cycle. After a programmable settle delay it captures the ROI output bus and serialises it back out. It sits in the static `top` between the pins and the `roi` instance, and replaces direct pin-to-ROI wiring whenever `DIN_N`/`DOUT_N` exceed the available pins.

## Interface
- `DIN_N`, default 8: ROI input bus width (≥1).
- `DOUT_N`, default 8: ROI output bus width (≥1).
- `LANES`, default 1: serial lanes per direction (1 ≤ LANES ≤ min(DIN_N, DOUT_N)).
- `SETTLE_CYCLES`, default 2: wait cycles between applying `roi_din` and capturing `roi_dout` (≥1).
- Derived: `IN_BEATS` = ceil(DIN_N/LANES); `OUT_BEATS` = ceil(DOUT_N/LANES).

Ports:
- `clk`  in  1  single clock. All logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a transaction. Sampled only in IDLE.
- `sin`  in  LANES  serial input word.
- `sin_valid`  in  1  `sin` carries a beat (meaningful in LOAD only).
- `sout`  out  LANES  serial output word.
- `sout_valid`  out  1  `sout` carries a beat.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on the final output beat.
- `roi_din`  out  DIN_N  registered drive to the ROI `din`.
- `roi_dout`  in  DOUT_N  ROI `dout`.

## Operation
- The FSM states are IDLE, LOAD, APPLY, SETTLE and UNLOAD.
- **IDLE**
  - If `start`=1, clear the beat counter and go to LOAD.
  - Otherwise stay in IDLE.
- **LOAD**
  - On each cycle with `sin_valid`=1, shift right: `shadow <= {sin, shadow[W-1:LANES]}`, where W = IN_BEATS·LANES. Increment the beat counter.
  - A cycle with `sin_valid`=0 stalls: shadow and counter hold.
  - When the IN_BEATS-th beat is taken, go to APPLY.
  - The first beat lands in the LSBs. Bits of `shadow` above DIN_N-1 are discarded.
- **APPLY**
  - Lasts one cycle: `roi_din <= shadow[DIN_N-1:0]`.
  - Load the settle counter with SETTLE_CYCLES and go to SETTLE.
- **SETTLE**
  - Decrement the settle counter each cycle.
  - In the cycle the counter equals 1, capture `outreg <= {zero-pad, roi_dout}` (width OUT_BEATS·LANES, zero-padded at the top), clear the beat counter and go to UNLOAD.
- **UNLOAD**
  - Every cycle: `sout_valid`=1 and `sout`=`outreg[LANES-1:0]`. On the clock edge, `outreg` shifts right by LANES.
  - There is no backpressure.
  - After OUT_BEATS beats, go to IDLE. `done`=1 during the final beat.
- `roi_din` holds its value between transactions. It changes only in APPLY and on `rst`.
- `start` is ignored while `busy`=1.
- `sin_valid` is ignored outside LOAD.
- Counters are sized to clog2(max(IN_BEATS, OUT_BEATS, SETTLE_CYCLES)+1) and never wrap.

## Timing
- Reset values:
  - state=IDLE
  - `roi_din`=0, shadow=0, outreg=0
  - `sout`=0, `sout_valid`=0, `busy`=0, `done`=0
- Reset mid-transaction aborts to IDLE on the next edge. A partially loaded shadow is never applied.
- `sout`, `sout_valid`, `busy` and `done` are decoded from registered state and outreg only. No input-to-output combinational path exists.
- With `start` seen in cycle 0 and no stalls:
  - LOAD occupies cycles 1..IN_BEATS.
  - APPLY is cycle IN_BEATS+1.
  - `roi_din` is new from cycle IN_BEATS+2.
  - SETTLE occupies SETTLE_CYCLES cycles.
  - The first `sout_valid` is in cycle IN_BEATS+2+SETTLE_CYCLES.
  - `done` is in cycle IN_BEATS+1+SETTLE_CYCLES+OUT_BEATS.
  - IDLE is reached the cycle after `done`.
- `roi_dout` is sampled exactly SETTLE_CYCLES cycles after `roi_din` updates. The ROI's combinational and registered paths must settle within that window.
- Back-to-back: `start` asserted in the cycle immediately after `done` is accepted, so there is one IDLE cycle between transactions.

## Test plan
- Setup for all scenarios: bench drives `roi_dout = ~roi_din` combinationally (DOUT_N = DIN_N).
- **Basic (LANES=1, SETTLE=2):**
  - Stimulus: `start` in cycle 0, then `sin` = bits of 0xA5 LSB-first in cycles 1..8.
  - Required: `roi_din`=0xA5 from cycle 10. `sout` = 0,1,0,1,1,0,1,0 (0x5A LSB-first) in cycles 12..19. `done` in cycle 19. `busy` low in cycle 20.
- **Multi-lane with padding (LANES=3, DIN_N=DOUT_N=8):**
  - Stimulus: beats 3'b101, 3'b010, 3'b111.
  - Required: `roi_din`=0xD5. Output beats 3'b010, 3'b101, 3'b000.
- **Stall:**
  - Stimulus: same as Basic, with `sin_valid` low for 3 cycles after beat 4.
  - Required: `roi_din`=0xA5, and every later event is delayed by exactly 3 cycles.
- **Ignored start:**
  - Stimulus: `start` pulsed during LOAD, SETTLE and UNLOAD.
  - Required: no effect on the transaction. `done` occurs once.
- **Reset mid-LOAD:**
  - Stimulus: `roi_din`=0xA5 from a prior transaction; `rst` asserted after 4 beats of 0x3C.
  - Required: next cycle state=IDLE, `roi_din`=0, `busy`=0. A following full transaction of 0x3C yields `roi_din`=0x3C.
- **Back-to-back:**
  - Stimulus: `start` asserted the cycle after `done`, loading 0x0F.
  - Required: accepted. `roi_din` goes 0xA5 → 0x0F. `sout` gives 0xF0 LSB-first.

Source files
------------

// File: rtl/roi_io_harness.sv
// rtl/roi_io_harness.sv - serial-to-parallel I/O harness between package pins and an ROI

module roi_io_harness #(
    parameter int DIN_N         = 8,
    parameter int DOUT_N        = 8,
    parameter int LANES         = 1,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LANES-1:0]  sin,
    input  logic              sin_valid,
    output logic [LANES-1:0]  sout,
    output logic              sout_valid,
    output logic              busy,
    output logic              done,
    output logic [DIN_N-1:0]  roi_din,
    input  logic [DOUT_N-1:0] roi_dout
);

    localparam int IN_BEATS  = (DIN_N + LANES - 1) / LANES;
    localparam int OUT_BEATS = (DOUT_N + LANES - 1) / LANES;
    localparam int W         = IN_BEATS * LANES;
    localparam int OW        = OUT_BEATS * LANES;
    localparam int MAX_IO    = (IN_BEATS > OUT_BEATS) ? IN_BEATS : OUT_BEATS;
    localparam int MAX_ALL   = (MAX_IO > SETTLE_CYCLES) ? MAX_IO : SETTLE_CYCLES;
    localparam int CW        = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] IN_LAST     = CW'(IN_BEATS - 1);
    localparam logic [CW-1:0] OUT_LAST    = CW'(OUT_BEATS - 1);
    localparam logic [CW-1:0] SETTLE_INIT = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_APPLY,
        S_SETTLE,
        S_UNLOAD
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   beat_cnt;
    logic [CW-1:0]   settle_cnt;
    logic [W-1:0]    shadow;
    logic [W-1:0]    shadow_shift;
    logic [OW-1:0]   outreg;
    logic [OW-1:0]   dout_pad;

    // New beats enter at the top so the first beat ends up in the LSBs
    generate
        if (IN_BEATS == 1) begin : g_shift_single
            assign shadow_shift = sin;
        end else begin : g_shift_multi
            assign shadow_shift = {sin, shadow[W-1:LANES]};
        end
    endgenerate

    // Zero-extend the ROI output to a whole number of lanes
    always_comb begin
        dout_pad                = '0;
        dout_pad[DOUT_N-1:0]    = roi_dout;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_LOAD;
            S_LOAD:   if (sin_valid && (beat_cnt == IN_LAST)) state_nx = S_APPLY;
            S_APPLY:  state_nx = S_SETTLE;
            S_SETTLE: if (settle_cnt == CNT_ONE) state_nx = S_UNLOAD;
            S_UNLOAD: if (beat_cnt == OUT_LAST) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Outputs depend only on registered state and outreg
    always_comb begin
        sout_valid = (state == S_UNLOAD);
        busy       = (state != S_IDLE);
        done       = (state == S_UNLOAD) && (beat_cnt == OUT_LAST);
        sout       = sout_valid ? outreg[LANES-1:0] : '0;
    end

    // Datapath: deserialise, apply, capture, serialise
    always_ff @(posedge clk) begin
        if (rst) begin
            roi_din    <= '0;
            shadow     <= '0;
            outreg     <= '0;
            beat_cnt   <= '0;
            settle_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) beat_cnt <= '0;
                end
                S_LOAD: begin
                    if (sin_valid) begin
                        shadow   <= shadow_shift;
                        beat_cnt <= beat_cnt + CNT_ONE;
                    end
                end
                S_APPLY: begin
                    roi_din    <= shadow[DIN_N-1:0];
                    settle_cnt <= SETTLE_INIT;
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt - CNT_ONE;
                    if (settle_cnt == CNT_ONE) begin
                        outreg   <= dout_pad;
                        beat_cnt <= '0;
                    end
                end
                S_UNLOAD: begin
                    outreg   <= outreg >> LANES;
                    beat_cnt <= beat_cnt + CNT_ONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_roi_io_harness.sv
// tb/tb_roi_io_harness.sv - directed scoreboard bench for roi_io_harness

module tb_roi_io_harness;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_a, sin_valid_a, sout_valid_a, busy_a, done_a;
    logic [0:0] sin_a, sout_a;
    logic [7:0] roi_din_a, roi_dout_a;
    logic       start_b, sin_valid_b, sout_valid_b, busy_b, done_b;
    logic [2:0] sin_b, sout_b;
    logic [7:0] roi_din_b, roi_dout_b;

    assign roi_dout_a = ~roi_din_a;
    assign roi_dout_b = ~roi_din_b;

    roi_io_harness #(.DIN_N(8), .DOUT_N(8), .LANES(1), .SETTLE_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .sin(sin_a), .sin_valid(sin_valid_a),
        .sout(sout_a), .sout_valid(sout_valid_a), .busy(busy_a), .done(done_a),
        .roi_din(roi_din_a), .roi_dout(roi_dout_a)
    );

    roi_io_harness #(.DIN_N(8), .DOUT_N(8), .LANES(3), .SETTLE_CYCLES(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .sin(sin_b), .sin_valid(sin_valid_b),
        .sout(sout_b), .sout_valid(sout_valid_b), .busy(busy_b), .done(done_b),
        .roi_din(roi_din_b), .roi_dout(roi_dout_b)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [2:0] qa[$];
    logic [4:0] qb[$];
    int first_a, done_a_cyc, done_a_cnt;
    int first_b, done_b_cyc;
    logic [7:0] rd;
    logic [2:0] bb[3];
    logic [8:0] sh_m, op_m;
    logic [7:0] din_m;
    int t0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [2:0] ea;
        logic [4:0] eb;
        @(negedge clk);
        if (sout_valid_a) begin
            total++;
            assert (qa.size() != 0) else begin
                bad++;
                $error("FAIL a_extra_beat observed=valid expected=no_beat cycle=%0d", cyc);
            end
            if (qa.size() != 0) begin
                ea = qa.pop_front();
                chk("a_sout", 32'(sout_a), 32'(ea[0]));
                chk("a_done", 32'(done_a), 32'(ea[1]));
                if (ea[2]) first_a = cyc;
            end
            if (done_a) begin
                done_a_cyc = cyc;
                done_a_cnt++;
            end
        end else begin
            chk("a_done_idle", 32'(done_a), 32'(0));
        end
        if (sout_valid_b) begin
            total++;
            assert (qb.size() != 0) else begin
                bad++;
                $error("FAIL b_extra_beat observed=valid expected=no_beat cycle=%0d", cyc);
            end
            if (qb.size() != 0) begin
                eb = qb.pop_front();
                chk("b_sout", 32'(sout_b), 32'(eb[2:0]));
                chk("b_done", 32'(done_b), 32'(eb[3]));
                if (eb[4]) first_b = cyc;
            end
            if (done_b) done_b_cyc = cyc;
        end else begin
            chk("b_done_idle", 32'(done_b), 32'(0));
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic txn_a(input logic [7:0] d, input logic [7:0] prev, input int stall_len, input bit noisy);
        int ts, dc0;
        ts         = cyc;
        dc0        = done_a_cnt;
        done_a_cyc = -1;
        first_a    = -1;
        for (int i = 0; i < 8; i++) qa.push_back({(i == 0), (i == 7), ~d[i]});
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                repeat (stall_len) begin
                    sin_valid_a = 1'b0;
                    sin_a       = ~d[i];
                    start_a     = noisy;
                    tick();
                end
            end
            sin_a       = d[i];
            sin_valid_a = 1'b1;
            start_a     = noisy && (i == 2);
            tick();
        end
        sin_valid_a = 1'b0;
        start_a     = 1'b0;
        chk("a_din_held_in_apply", 32'(roi_din_a), 32'(prev));
        chk("a_busy_apply", 32'(busy_a), 32'(1));
        tick();
        chk("a_din_new", 32'(roi_din_a), 32'(d));
        for (int k = 0; k < 40 && done_a_cyc < 0; k++) begin
            start_a = noisy && (k == 0 || k == 5);
            tick();
        end
        start_a = 1'b0;
        chk("a_done_cycle", 32'(done_a_cyc - ts), 32'(19 + stall_len));
        chk("a_first_beat_cycle", 32'(first_a - ts), 32'(12 + stall_len));
        chk("a_done_once", 32'(done_a_cnt - dc0), 32'(1));
        chk("a_busy_after_done", 32'(busy_a), 32'(0));
    endtask

    initial begin
        rst         = 1'b1;
        start_a     = 1'b0;
        sin_a       = '0;
        sin_valid_a = 1'b0;
        start_b     = 1'b0;
        sin_b       = '0;
        sin_valid_b = 1'b0;
        done_a_cnt  = 0;
        done_a_cyc  = -1;
        done_b_cyc  = -1;
        first_a     = -1;
        first_b     = -1;
        @(posedge clk);
        #1;
        tick();
        rst = 1'b0;

        // reset state
        chk("rst_roi_din_a", 32'(roi_din_a), 32'(0));
        chk("rst_busy_a", 32'(busy_a), 32'(0));
        chk("rst_sout_valid_a", 32'(sout_valid_a), 32'(0));
        chk("rst_sout_a", 32'(sout_a), 32'(0));
        chk("rst_done_a", 32'(done_a), 32'(0));
        chk("rst_roi_din_b", 32'(roi_din_b), 32'(0));
        chk("rst_busy_b", 32'(busy_b), 32'(0));

        // three lanes with a padded final beat
        bb[0] = 3'b101;
        bb[1] = 3'b010;
        bb[2] = 3'b111;
        sh_m  = {bb[2], bb[1], bb[0]};
        din_m = sh_m[7:0];
        op_m  = {1'b0, ~din_m};
        for (int j = 0; j < 3; j++) qb.push_back({(j == 0), (j == 2), op_m[3*j +: 3]});
        t0 = cyc;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int j = 0; j < 3; j++) begin
            sin_b       = bb[j];
            sin_valid_b = 1'b1;
            tick();
        end
        sin_valid_b = 1'b0;
        tick();
        chk("b_roi_din", 32'(roi_din_b), 32'(8'hD5));
        for (int k = 0; k < 30 && done_b_cyc < 0; k++) tick();
        chk("b_done_cycle", 32'(done_b_cyc - t0), 32'(9));
        chk("b_first_beat_cycle", 32'(first_b - t0), 32'(7));
        chk("b_busy_after", 32'(busy_b), 32'(0));
        chk("b_queue_drained", 32'(qb.size()), 32'(0));

        // single lane: basic, stalled, ignored starts
        txn_a(8'hA5, 8'h00, 0, 1'b0);
        txn_a(8'hA5, 8'hA5, 3, 1'b0);
        txn_a(8'h96, 8'hA5, 0, 1'b1);
        repeat (4) tick();
        chk("a_noisy_no_restart", 32'(busy_a), 32'(0));

        // back-to-back
        txn_a(8'hA5, 8'h96, 0, 1'b0);
        txn_a(8'h0F, 8'hA5, 0, 1'b0);
        txn_a(8'hA5, 8'h0F, 0, 1'b0);

        // reset part way through LOAD
        rd = 8'h3C;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sin_a       = rd[i];
            sin_valid_a = 1'b1;
            tick();
        end
        sin_valid_a = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_busy", 32'(busy_a), 32'(0));
        chk("rst_mid_roi_din", 32'(roi_din_a), 32'(0));
        chk("rst_mid_sout_valid", 32'(sout_valid_a), 32'(0));
        repeat (2) tick();
        chk("rst_mid_stays_idle", 32'(busy_a), 32'(0));
        txn_a(8'h3C, 8'h00, 0, 1'b0);
        repeat (3) tick();
        chk("a_queue_drained", 32'(qa.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
